// File: rtl/wb_slave_mem.sv
// wb_slave_mem: Wishbone classic slave memory for the RMAP target address space
// ADDR_MIN..ADDR_MAX-1. It performs single-word reads and writes with per-byte
// write lanes and WAIT_STATES extra cycles before each response. Misaligned
// accesses and accesses with sel=0 terminate with errOut.
// Optional feature: define WB_SLAVE_MEM_BOUNDS_CHECK_EN to also reject addresses
// outside ADDR_MIN..ADDR_MAX-1. Without it, the word index wraps modulo depth.
module wb_slave_mem #(
    parameter int unsigned ADDR_MIN    = 0,
    parameter int unsigned ADDR_MAX    = 2048,
    parameter int unsigned BUS_WIDTH   = 32,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cycIn,
    input  logic                   stbIn,
    input  logic [31:0]            adrIn,
    input  logic [BUS_WIDTH/8-1:0] selIn,
    input  logic                   weIn,
    input  logic [BUS_WIDTH-1:0]   datIn,
    output logic [BUS_WIDTH-1:0]   datOut,
    output logic                   ackOut,
    output logic                   errOut
);

    localparam int unsigned BYTES      = BUS_WIDTH / 8;
    localparam int unsigned OFF_BITS   = $clog2(BYTES);
    localparam int unsigned DEPTH      = (ADDR_MAX - ADDR_MIN) / BYTES;
    localparam int unsigned IDX_BITS   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] ALIGN_MASK = 32'(BYTES - 1);
    localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [IDX_BITS-1:0]   idx_q;
    logic                  we_q;
    logic [BYTES-1:0]      sel_q;
    logic [BUS_WIDTH-1:0]  dat_q;
    logic                  legal_q;

    logic                  req;
    logic                  req_legal;
    logic [IDX_BITS-1:0]   idx_in;

    logic                  commit;
    logic                  c_legal;
    logic                  c_we;
    logic [BYTES-1:0]      c_sel;
    logic [BUS_WIDTH-1:0]  c_dat;
    logic [IDX_BITS-1:0]   c_idx;

    logic [BUS_WIDTH-1:0]  mem [DEPTH];

    assign req    = cycIn & stbIn;
    assign idx_in = IDX_BITS'((adrIn - ADDR_MIN) >> OFF_BITS);

`ifdef WB_SLAVE_MEM_BOUNDS_CHECK_EN
    logic [32:0] span_off;
    logic        in_range;

    // Range check via 33-bit subtract: the borrow bit flags adrIn < ADDR_MIN
    always_comb begin
        span_off = {1'b0, adrIn} - 33'(ADDR_MIN);
        in_range = !span_off[32] && (span_off[31:0] < 32'(ADDR_MAX - ADDR_MIN));
    end
`else
    logic in_range;
    assign in_range = 1'b1;
`endif

    // Legality of the request currently presented on the bus
    always_comb begin
        req_legal = ((adrIn & ALIGN_MASK) == '0) && (selIn != '0) && in_range;
    end

    // Access happens on the edge entering RESP. With zero wait states that edge is
    // the sampling edge itself, so the live bus fields are used instead of the latch.
    always_comb begin
        commit  = 1'b0;
        c_legal = legal_q;
        c_we    = we_q;
        c_sel   = sel_q;
        c_dat   = dat_q;
        c_idx   = idx_q;
        if (state == IDLE) begin
            c_legal = req_legal;
            c_we    = weIn;
            c_sel   = selIn;
            c_dat   = datIn;
            c_idx   = idx_in;
            commit  = req && (WAIT_STATES == 0);
        end else if (state == WAIT) begin
            commit = cycIn && (cnt == 4'd1);
        end
    end

    // Transfer FSM, registered terminations, read data and memory write port.
    // The memory is not touched by reset; keeping it in this block makes a
    // write that coincides with rst impossible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ackOut  <= 1'b0;
            errOut  <= 1'b0;
            datOut  <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            legal_q <= 1'b0;
        end else begin
            ackOut <= 1'b0;
            errOut <= 1'b0;
            if (commit && c_legal) begin
                if (c_we) begin
                    for (int unsigned i = 0; i < BYTES; i++) begin
                        if (c_sel[i]) begin
                            mem[c_idx][8*i +: 8] <= c_dat[8*i +: 8];
                        end
                    end
                end else begin
                    datOut <= mem[c_idx];
                end
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        idx_q   <= idx_in;
                        we_q    <= weIn;
                        sel_q   <= selIn;
                        dat_q   <= datIn;
                        legal_q <= req_legal;
                        cnt     <= WAIT_LOAD;
                        state   <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (!cycIn) begin
                        state <= IDLE;
                    end else if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    ackOut <= legal_q;
                    errOut <= !legal_q;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_slave_mem.sv
// tb_wb_slave_mem: self-checking bench for wb_slave_mem. Three instances
// (WAIT_STATES = 0, 4, 3) are driven against a word-array reference model.
module tb_wb_slave_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst3;
    logic [2:0]  cyc_v;
    logic [2:0]  stb_v;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
    logic [2:0]  ack_v;
    logic [2:0]  err_v;
    logic [31:0] dout_v [3];

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: one word array and the last read value per instance
    logic [31:0] mem_m   [3][512];
    logic [31:0] last_rd [3];

    always #5 clk = ~clk;

    wb_slave_mem #(.ADDR_MIN(0), .ADDR_MAX(2048), .BUS_WIDTH(32), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .cycIn(cyc_v[0]), .stbIn(stb_v[0]), .adrIn(adr),
        .selIn(sel), .weIn(we), .datIn(dat), .datOut(dout_v[0]),
        .ackOut(ack_v[0]), .errOut(err_v[0])
    );

    wb_slave_mem #(.ADDR_MIN(0), .ADDR_MAX(2048), .BUS_WIDTH(32), .WAIT_STATES(4)) dut4 (
        .clk(clk), .rst(rst), .cycIn(cyc_v[1]), .stbIn(stb_v[1]), .adrIn(adr),
        .selIn(sel), .weIn(we), .datIn(dat), .datOut(dout_v[1]),
        .ackOut(ack_v[1]), .errOut(err_v[1])
    );

    wb_slave_mem #(.ADDR_MIN(0), .ADDR_MAX(2048), .BUS_WIDTH(32), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst3), .cycIn(cyc_v[2]), .stbIn(stb_v[2]), .adrIn(adr),
        .selIn(sel), .weIn(we), .datIn(dat), .datOut(dout_v[2]),
        .ackOut(ack_v[2]), .errOut(err_v[2])
    );

    function automatic int unsigned wait_of(input int unsigned d);
        case (d)
            0:       return 0;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete transfer on instance d, checked against the model
    task automatic xfer(input int unsigned d, input logic [31:0] a, input logic w,
                        input logic [3:0] s, input logic [31:0] wd);
        int unsigned n;
        int unsigned widx;
        logic        legal;
        logic [31:0] m;
        logic [1:0]  low;
        low   = a[1:0];
        legal = (low == 2'b00) && (s != 4'h0);
`ifdef WB_SLAVE_MEM_BOUNDS_CHECK_EN
        if (a >= 32'd2048) legal = 1'b0;
`endif
        widx = (a / 4) % 512;
        adr = a; we = w; sel = s; dat = wd;
        cyc_v[d] = 1'b1; stb_v[d] = 1'b1;
        @(posedge clk); #1;
        stb_v[d] = 1'b0;
        check("no_early_term", {62'd0, ack_v[d], err_v[d]}, 64'd0);
        n = 0;
        while (!(ack_v[d] || err_v[d]) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 64'(n), 64'(1 + wait_of(d)));
        check("term_kind", {62'd0, ack_v[d], err_v[d]}, legal ? 64'd2 : 64'd1);
        if (legal && w) begin
            m = mem_m[d][widx];
            for (int i = 0; i < 4; i++) begin
                if (s[i]) m[8*i +: 8] = wd[8*i +: 8];
            end
            mem_m[d][widx] = m;
        end else if (legal) begin
            last_rd[d] = mem_m[d][widx];
        end
        check("dat_out", {32'd0, dout_v[d]}, {32'd0, last_rd[d]});
        cyc_v[d] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [3:0]  rs;
        int unsigned quiet;

        rst = 1'b1; rst3 = 1'b1;
        cyc_v = '0; stb_v = '0;
        adr = '0; sel = '0; we = 1'b0; dat = '0;
        for (int d = 0; d < 3; d++) last_rd[d] = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("reset_term", {62'd0, ack_v[d], err_v[d]}, 64'd0);
            check("reset_dat", {32'd0, dout_v[d]}, 64'd0);
        end
        rst = 1'b0; rst3 = 1'b0;
        @(posedge clk); #1;

        // Basic write / read, zero wait states
        xfer(0, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF);
        xfer(0, 32'h10, 1'b0, 4'hF, 32'h0);
        check("basic_read", {32'd0, dout_v[0]}, 64'hDEADBEEF);

        // Byte lanes
        xfer(0, 32'h20, 1'b1, 4'hF, 32'hDEADBEEF);
        xfer(0, 32'h20, 1'b1, 4'h5, 32'h11223344);
        xfer(0, 32'h20, 1'b0, 4'h1, 32'h0);
        check("lane_read", {32'd0, dout_v[0]}, 64'hDE22BE44);

        // Error cases
        xfer(0, 32'h802, 1'b0, 4'hF, 32'h0);
        xfer(0, 32'h10, 1'b1, 4'h0, 32'h12345678);
        xfer(0, 32'h10, 1'b0, 4'hF, 32'h0);
        check("sel0_no_write", {32'd0, dout_v[0]}, 64'hDEADBEEF);
        xfer(0, 32'h0, 1'b1, 4'hF, 32'hA5A5A5A5);
        xfer(0, 32'h800, 1'b1, 4'hF, 32'h0F0F0F0F);
        xfer(0, 32'h0, 1'b0, 4'hF, 32'h0);

        // 512 back-to-back writes of the index, then reads
        for (int i = 0; i < 512; i++) xfer(0, 32'(i * 4), 1'b1, 4'hF, 32'(i));
        for (int i = 0; i < 512; i++) xfer(0, 32'(i * 4), 1'b0, 4'hF, 32'h0);

        // Randomised mix including misaligned, out-of-range and sel=0 accesses
        for (int i = 0; i < 300; i++) begin
            ra = 32'($urandom_range(0, 2300));
            if ($urandom_range(0, 3) != 0) ra = ra & 32'hFFFF_FFFC;
            rs = 4'($urandom_range(0, 15));
            xfer(0, ra, 1'($urandom_range(0, 1)), rs, $urandom);
        end

        // Four wait states: latency and cycle abort
        xfer(1, 32'h40, 1'b1, 4'hF, 32'hCAFEF00D);
        xfer(1, 32'h40, 1'b0, 4'hF, 32'h0);
        adr = 32'h40; we = 1'b1; sel = 4'hF; dat = 32'h0BADBAD0;
        cyc_v[1] = 1'b1; stb_v[1] = 1'b1;
        @(posedge clk); #1;
        stb_v[1] = 1'b0;
        @(posedge clk); #1;
        cyc_v[1] = 1'b0;
        quiet = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack_v[1] || err_v[1]) quiet++;
        end
        check("abort_no_term", 64'(quiet), 64'd0);
        check("abort_dat_held", {32'd0, dout_v[1]}, 64'hCAFEF00D);
        xfer(1, 32'h40, 1'b0, 4'hF, 32'h0);

        // Reset in the middle of a three-wait-state write
        xfer(2, 32'h30, 1'b1, 4'hF, 32'hAAAAAAAA);
        xfer(2, 32'h30, 1'b0, 4'hF, 32'h0);
        adr = 32'h30; we = 1'b1; sel = 4'hF; dat = 32'h55555555;
        cyc_v[2] = 1'b1; stb_v[2] = 1'b1;
        @(posedge clk); #1;
        stb_v[2] = 1'b0;
        @(posedge clk); #1;
        rst3 = 1'b1;
        #1;
        check("midrst_term", {62'd0, ack_v[2], err_v[2]}, 64'd0);
        check("midrst_dat", {32'd0, dout_v[2]}, 64'd0);
        last_rd[2] = '0;
        cyc_v[2] = 1'b0;
        @(posedge clk); #1;
        check("midrst_term_held", {62'd0, ack_v[2], err_v[2]}, 64'd0);
        rst3 = 1'b0;
        @(posedge clk); #1;
        xfer(2, 32'h30, 1'b0, 4'hF, 32'h0);
        check("midrst_no_write", {32'd0, dout_v[2]}, 64'hAAAAAAAA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
